// File: rtl/inst_ram_loader_pkg.sv
// Shared constants for the instruction RAM loader: FSM encoding, RAM geometry
// and the word-count clamp.
package inst_ram_loader_pkg;

    localparam int INST_ADDR_W    = 6;
    localparam int INST_WORD_W    = 32;
    localparam int INST_WORDS     = 64;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [INST_ADDR_W:0] MAX_WORDS = (INST_ADDR_W+1)'(INST_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Requests larger than the RAM load the whole RAM rather than wrapping.
    function automatic logic [INST_ADDR_W:0] clamp_words(input logic [INST_ADDR_W:0] lw);
        return (lw > MAX_WORDS) ? MAX_WORDS : lw;
    endfunction

endpackage

// File: rtl/inst_ram_loader_if.sv
// Byte-stream, RAM-write and status signals of the instruction RAM loader.
interface inst_ram_loader_if import inst_ram_loader_pkg::*; ();

    logic                   start;
    logic [INST_ADDR_W:0]   load_words;
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   ram_we;
    logic [INST_ADDR_W-1:0] ram_addr;
    logic [INST_WORD_W-1:0] ram_din;
    logic                   busy;
    logic                   cpu_hold;
    logic                   done;
    logic [INST_WORD_W-1:0] checksum;

    modport slave (
        input  start, load_words, byte_valid, byte_data,
        output byte_ready, ram_we, ram_addr, ram_din, busy, cpu_hold, done, checksum
    );

    modport master (
        output start, load_words, byte_valid, byte_data,
        input  byte_ready, ram_we, ram_addr, ram_din, busy, cpu_hold, done, checksum
    );

endinterface

// File: rtl/inst_ram_loader_word_assembler.sv
// Packs four stream bytes into one big-endian instruction word; the first
// byte of a word ends up in bits 31:24.
module inst_ram_loader_word_assembler import inst_ram_loader_pkg::*; (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   xfer,
    input  logic [7:0]             byte_data,
    output logic [INST_WORD_W-1:0] word,
    output logic                   word_valid
);

    logic [INST_WORD_W-9:0] shift_q;
    logic [1:0]             byte_cnt_q;

    // Shift accepted bytes in from the bottom; clr drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (clr) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (xfer) begin
            shift_q    <= {shift_q[INST_WORD_W-17:0], byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

    // The completed word is presented in the same cycle as its last byte.
    assign word       = {shift_q, byte_data};
    assign word_valid = xfer && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_ram_loader.sv
// Loads a byte stream into the instruction RAM word by word, holding the CPU
// in reset until the whole program image has been written.
module inst_ram_loader import inst_ram_loader_pkg::*; #(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int WORD_W = INST_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    inst_ram_loader_if.slave bus
);

    logic [1:0]        state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [WORD_W-1:0] ram_din_q;
    logic [WORD_W-1:0] checksum_q;
    logic              zero_q;
    logic              xfer;
    logic              asm_clr;
    logic [WORD_W-1:0] asm_word;
    logic              asm_word_valid;

    assign xfer    = bus.byte_valid && (state_q == ST_RECV);
    assign asm_clr = (state_q == ST_IDLE) && bus.start;

    inst_ram_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .xfer       (xfer),
        .byte_data  (bus.byte_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // Sequencing FSM with the word address counter and the running checksum.
    // A zero-length load spends one settle cycle in DONE (zero_q) so its done
    // pulse lands two cycles after start, with no RAM traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            checksum_q <= '0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        checksum_q <= '0;
                        if (bus.load_words != '0) begin
                            n_q        <= clamp_words(bus.load_words);
                            word_idx_q <= '0;
                            state_q    <= ST_RECV;
                        end else begin
                            zero_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RECV: begin
                    if (asm_word_valid) begin
                        ram_din_q  <= asm_word;
                        ram_addr_q <= word_idx_q;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    checksum_q <= checksum_q + ram_din_q;
                    if ({1'b0, word_idx_q} == n_q - 1'b1) begin
                        state_q <= ST_DONE;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= ST_RECV;
                    end
                end
                default: begin
                    if (zero_q) begin
                        zero_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs decode from state so reset removes them without a clock edge.
    assign bus.byte_ready = (state_q == ST_RECV);
    assign bus.ram_we     = (state_q == ST_WRITE);
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.cpu_hold   = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE) && !zero_q;
    assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;
    import inst_ram_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;

    inst_ram_loader_if bus ();

    inst_ram_loader #(.ADDR_W(INST_ADDR_W), .WORD_W(INST_WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words_q[$];
    logic [7:0]  stream_q[$];
    logic [5:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          done_cyc;
    bit          timed_out;
    bit          hold_ok;
    int          n_xfer;

    // Reference: a load writes min(lw,64) words in order; checksum is their mod-2^32 sum.
    function automatic int model_n(input int lw);
        return (lw > 64) ? 64 : lw;
    endfunction

    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s = 32'h0;
        for (int i = 0; i < n; i++) s = s + words_q[i];
        return s;
    endfunction

    task automatic build_stream();
        logic [31:0] w;
        stream_q.delete();
        foreach (words_q[i]) begin
            w = words_q[i];
            stream_q.push_back(w[31:24]);
            stream_q.push_back(w[23:16]);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(w[7:0]);
        end
    endtask

    // mode 0: continuous bytes, 1: valid on alternate cycles, 2: random valid
    task automatic run_load(input int lw, input int mode, input int mid_start_cyc);
        int idx = 0;
        bit v;
        build_stream();
        got_addr.delete();
        got_data.delete();
        done_cyc  = -1;
        timed_out = 1'b0;
        hold_ok   = 1'b1;
        n_xfer    = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.load_words = 7'(lw);
        bus.byte_valid = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            bus.start      = (k == mid_start_cyc);
            bus.load_words = (k == mid_start_cyc) ? 7'd3 : 7'(lw);
            if (bus.ram_we) begin
                got_addr.push_back(bus.ram_addr);
                got_data.push_back(bus.ram_din);
            end
            if (!bus.busy || !bus.cpu_hold) hold_ok = 1'b0;
            if (bus.done) begin
                done_cyc = k;
                bus.byte_valid = 1'b0;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 1);
                default: v = ($urandom_range(99) < 60);
            endcase
            if (idx >= stream_q.size()) v = 1'b0;
            bus.byte_valid = v;
            bus.byte_data  = v ? stream_q[idx] : 8'($urandom);
            if (v && bus.byte_ready) begin
                idx++;
                n_xfer++;
            end
        end
        bus.start = 1'b0;
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.load_words = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        #12;
        n_checks++;
        if ({bus.byte_ready, bus.ram_we, bus.ram_addr, bus.ram_din, bus.busy, bus.cpu_hold,
             bus.done, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b we=%b addr=%0d din=%h sum=%h, want all zero",
                     bus.busy, bus.ram_we, bus.ram_addr, bus.ram_din, bus.checksum);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_two_words();
        logic [31:0] sum_hold;
        words_q = '{32'h20080005, 32'h08000000};
        run_load(2, 0, 0);
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL two_timeout: got %b want 0", timed_out); end
        n_checks++;
        if (got_addr.size() !== 2) begin
            n_fail++; $display("FAIL two_nwrites: got %0d want 2", got_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_addr[i] !== 6'(i) || got_data[i] !== words_q[i]) begin
                    n_fail++;
                    $display("FAIL two_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             i, got_addr[i], got_data[i], i, words_q[i]);
                end
            end
        end
        n_checks++;
        if (done_cyc !== 11) begin n_fail++; $display("FAIL two_done_cycle: got %0d want 11", done_cyc); end
        n_checks++;
        if (bus.checksum !== 32'h28080005) begin
            n_fail++; $display("FAIL two_checksum: got %h want 28080005", bus.checksum);
        end
        n_checks++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL two_hold: busy/cpu_hold dropped during load"); end
        sum_hold = bus.checksum;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.cpu_hold, bus.done, bus.ram_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL two_idle_after: got busy=%b hold=%b done=%b we=%b want 0000",
                     bus.busy, bus.cpu_hold, bus.done, bus.ram_we);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.checksum !== sum_hold || bus.ram_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL two_hold_after: got sum=%h addr=%0d want sum=%h addr=1",
                     bus.checksum, bus.ram_addr, sum_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        bus.start = 1'b1;
        bus.load_words = 7'd1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h20;
        @(negedge clk);
        bus.byte_data = 8'h08;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.byte_ready, bus.ram_we, bus.ram_addr, bus.ram_din, bus.busy, bus.cpu_hold,
             bus.done, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b busy=%b addr=%0d din=%h sum=%h, want all zero",
                     bus.byte_ready, bus.busy, bus.ram_addr, bus.ram_din, bus.checksum);
        end
        @(negedge clk);
        rst = 1'b0;
        words_q = '{32'h20080005};
        run_load(1, 0, 0);
        n_checks++;
        if (got_addr.size() !== 1 || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL midreset_nwrites: got %0d timeout=%b want 1 write", got_addr.size(), timed_out);
        end else begin
            n_checks++;
            if (got_addr[0] !== 6'd0 || got_data[0] !== 32'h20080005) begin
                n_fail++;
                $display("FAIL midreset_word: got addr=%0d data=%h want addr=0 data=20080005",
                         got_addr[0], got_data[0]);
            end
        end
        n_checks++;
        if (bus.checksum !== 32'h20080005) begin
            n_fail++; $display("FAIL midreset_checksum: got %h want 20080005", bus.checksum);
        end
    endtask

    task automatic test_stall();
        words_q = '{32'($urandom)};
        run_load(1, 1, 0);
        n_checks++;
        if (timed_out !== 1'b0 || n_xfer !== 4) begin
            n_fail++; $display("FAIL stall_xfers: got %0d timeout=%b want 4", n_xfer, timed_out);
        end
        n_checks++;
        if (got_addr.size() !== 1) begin
            n_fail++; $display("FAIL stall_nwrites: got %0d want 1", got_addr.size());
        end else begin
            n_checks++;
            if (got_data[0] !== words_q[0] || got_addr[0] !== 6'd0) begin
                n_fail++; $display("FAIL stall_word: got %h@%0d want %h@0", got_data[0], got_addr[0], words_q[0]);
            end
        end
        n_checks++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: busy/cpu_hold dropped during load"); end
    endtask

    task automatic test_zero();
        words_q.delete();
        run_load(0, 0, 0);
        n_checks++;
        if (got_addr.size() !== 0) begin
            n_fail++; $display("FAIL zero_nwrites: got %0d want 0", got_addr.size());
        end
        n_checks++;
        if (done_cyc !== 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
        n_checks++;
        if (bus.checksum !== 32'h0) begin n_fail++; $display("FAIL zero_checksum: got %h want 0", bus.checksum); end
    endtask

    task automatic test_full();
        int bad = 0;
        words_q.delete();
        for (int k = 0; k < 64; k++) words_q.push_back(32'(k));
        run_load(100, 0, 50);
        n_checks++;
        if (timed_out !== 1'b0 || got_addr.size() !== model_n(100)) begin
            n_fail++; $display("FAIL full_nwrites: got %0d timeout=%b want 64", got_addr.size(), timed_out);
        end else begin
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if (got_addr[i] !== 6'(i) || got_data[i] !== 32'(i)) begin
                    n_fail++;
                    if (bad++ < 4)
                        $display("FAIL full_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                                 i, got_addr[i], got_data[i], i, i);
                end
            end
        end
        n_checks++;
        if (bus.checksum !== 32'd2016) begin
            n_fail++; $display("FAIL full_checksum: got %0d want 2016", bus.checksum);
        end
        n_checks++;
        if (done_cyc !== 5 * 64 + 1) begin
            n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, 5 * 64 + 1);
        end
    endtask

    task automatic test_wrap();
        words_q = '{32'hFFFFFFFF, 32'h00000002};
        run_load(2, 2, 0);
        n_checks++;
        if (timed_out !== 1'b0 || got_addr.size() !== 2) begin
            n_fail++; $display("FAIL wrap_nwrites: got %0d timeout=%b want 2", got_addr.size(), timed_out);
        end
        n_checks++;
        if (bus.checksum !== 32'h00000001) begin
            n_fail++; $display("FAIL wrap_checksum: got %h want 00000001", bus.checksum);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int lw = $urandom_range(1, 10);
            int n  = model_n(lw);
            logic [31:0] sum_hold;
            words_q.delete();
            for (int k = 0; k < n; k++) words_q.push_back(32'($urandom));
            run_load(lw, 2, 0);
            n_checks++;
            if (timed_out !== 1'b0 || got_addr.size() !== n) begin
                n_fail++;
                $display("FAIL rand%0d_nwrites: got %0d timeout=%b want %0d", it, got_addr.size(), timed_out, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (got_addr[i] !== 6'(i) || got_data[i] !== words_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                                 it, i, got_addr[i], got_data[i], i, words_q[i]);
                    end
                end
            end
            n_checks++;
            if (bus.checksum !== model_sum(n) || hold_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_checksum: got %h hold_ok=%b want %h", it, bus.checksum, hold_ok, model_sum(n));
            end
            sum_hold = model_sum(n);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            n_checks++;
            if (bus.checksum !== sum_hold || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_idle: got sum=%h busy=%b want sum=%h busy=0", it, bus.checksum, bus.busy, sum_hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_reset_mid_load();
        test_stall();
        test_zero();
        test_full();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
